// File: rtl/cpr_freq_meter.sv
// cpr_freq_meter: counts rising edges of four asynchronous CPR clocks over a
// programmable CLK window. Threshold alarms are built only with CPR_FM_THRESH_EN.
module cpr_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic [WIN_W-1:0] WIN_CYCLES,
  input  logic             LOGICCPR_1,
  input  logic             LOGICCPR_2,
  input  logic             LOGICCPR_3,
  input  logic             LOGICCPR_4,
  input  logic [CNT_W-1:0] THRESH_1,
  input  logic [CNT_W-1:0] THRESH_2,
  input  logic [CNT_W-1:0] THRESH_3,
  input  logic [CNT_W-1:0] THRESH_4,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] CNT_1,
  output logic [CNT_W-1:0] CNT_2,
  output logic [CNT_W-1:0] CNT_3,
  output logic [CNT_W-1:0] CNT_4,
  output logic [3:0]       SAT,
  output logic [3:0]       ALARM
);

  localparam int            AW       = $clog2(SYNC_STAGES + 2);
  localparam logic [AW-1:0] ARM_LAST = AW'(SYNC_STAGES);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_DONE} state_t;

  state_t                      r_state, w_state_nxt;
  logic [3:0]                  w_cpr;
  logic [3:0][SYNC_STAGES-1:0] r_sync;
  logic [3:0]                  r_dly, w_edge;
  logic [3:0][CNT_W-1:0]       r_cnt, w_cnt_nxt, r_cnt_out, w_thr;
  logic [3:0]                  r_sat, w_sat_nxt, r_sat_out, r_alarm, w_alarm;
  logic [AW-1:0]               r_arm_cnt;
  logic [WIN_W-1:0]            r_win_left;
  logic                        w_accept, w_load;

  assign w_cpr = {LOGICCPR_4, LOGICCPR_3, LOGICCPR_2, LOGICCPR_1};
  assign w_thr = {THRESH_4, THRESH_3, THRESH_2, THRESH_1};

  // Synchronizers and delay flops run in every state so ARM can flush history.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_sync <= '0;
      r_dly  <= '0;
    end else begin
      for (int unsigned c = 0; c < 4; c++) begin
        r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], w_cpr[c]};
        r_dly[c]  <= r_sync[c][SYNC_STAGES-1];
      end
    end
  end

  always_comb begin
    w_edge = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      w_edge[c] = r_sync[c][SYNC_STAGES-1] & ~r_dly[c];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_nxt = S_ARM;
          w_accept    = 1'b1;
        end
      end
      S_ARM: begin
        if (r_arm_cnt == ARM_LAST) begin
          w_state_nxt = (r_win_left == '0) ? S_DONE : S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (r_win_left == WIN_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (START) begin
          w_state_nxt = S_ARM;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_load = (w_state_nxt == S_DONE) && (r_state != S_DONE);

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state    <= S_IDLE;
      r_arm_cnt  <= '0;
      r_win_left <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_arm_cnt  <= '0;
        r_win_left <= WIN_CYCLES;
      end else if (r_state == S_ARM) begin
        r_arm_cnt <= r_arm_cnt + 1'b1;
      end else if (r_state == S_MEASURE) begin
        r_win_left <= r_win_left - 1'b1;
      end
    end
  end

  // An edge that finds the counter already full holds it and marks saturation.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_sat_nxt = r_sat;
    if (r_state == S_MEASURE) begin
      for (int unsigned c = 0; c < 4; c++) begin
        if (w_edge[c]) begin
          if (&r_cnt[c]) begin
            w_sat_nxt[c] = 1'b1;
          end else begin
            w_cnt_nxt[c] = r_cnt[c] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_cnt <= '0;
      r_sat <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_sat <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sat <= w_sat_nxt;
    end
  end

`ifdef CPR_FM_THRESH_EN
  always_comb begin
    w_alarm = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      w_alarm[c] = ~w_sat_nxt[c] & (w_cnt_nxt[c] < w_thr[c]);
    end
  end
`else
  logic w_unused_thr;
  assign w_unused_thr = ^w_thr;
  assign w_alarm      = '0;
`endif

  // Results are captured on the edge entering DONE so they are visible during it.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_cnt_out <= '0;
      r_sat_out <= '0;
      r_alarm   <= '0;
    end else if (w_load) begin
      r_cnt_out <= w_cnt_nxt;
      r_sat_out <= w_sat_nxt;
      r_alarm   <= w_alarm;
    end
  end

  assign BUSY  = (r_state == S_ARM) || (r_state == S_MEASURE);
  assign DONE  = (r_state == S_DONE);
  assign CNT_1 = r_cnt_out[0];
  assign CNT_2 = r_cnt_out[1];
  assign CNT_3 = r_cnt_out[2];
  assign CNT_4 = r_cnt_out[3];
  assign SAT   = r_sat_out;
  assign ALARM = r_alarm;

endmodule

// File: tb/tb_cpr_freq_meter.sv
// Scoreboard bench for cpr_freq_meter: a 16-bit instance for nominal/alarm/handshake
// cases and an 8-bit instance with a fast channel 2 for saturation.
module tb_cpr_freq_meter;

`ifdef CPR_FM_THRESH_EN
  localparam bit TH = 1'b1;
`else
  localparam bit TH = 1'b0;
`endif

  typedef struct {
    int               exp_cyc;
    logic [3:0][15:0] lo;
    logic [3:0][15:0] hi;
    logic [3:0]       sat;
    logic [3:0]       alarm;
  } exp_t;

  logic CLK = 1'b0;
  logic RN;
  logic START_a, START_b;
  logic [15:0] WIN_a, WIN_b;
  logic [15:0] TH1, TH2, TH3, TH4;
  logic c_slow = 1'b0;
  logic c_fast = 1'b0;
  logic hold3;
  logic cpr3;
  logic BUSY_a, DONE_a, BUSY_b, DONE_b;
  logic [15:0] CA1, CA2, CA3, CA4;
  logic [7:0]  CB1, CB2, CB3, CB4;
  logic [3:0]  SAT_a, ALARM_a, SAT_b, ALARM_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dn_a = 0;
  int dn_b = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #3;
    forever begin #40; c_slow = ~c_slow; end
  end
  initial begin
    #3;
    forever begin #15; c_fast = ~c_fast; end
  end
  assign cpr3 = hold3 ? 1'b1 : c_slow;

  cpr_freq_meter #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(2)) u_a (
    .CLK(CLK), .RN(RN), .START(START_a), .WIN_CYCLES(WIN_a),
    .LOGICCPR_1(c_slow), .LOGICCPR_2(c_slow), .LOGICCPR_3(cpr3), .LOGICCPR_4(c_slow),
    .THRESH_1(TH1), .THRESH_2(TH2), .THRESH_3(TH3), .THRESH_4(TH4),
    .BUSY(BUSY_a), .DONE(DONE_a), .CNT_1(CA1), .CNT_2(CA2), .CNT_3(CA3), .CNT_4(CA4),
    .SAT(SAT_a), .ALARM(ALARM_a)
  );

  cpr_freq_meter #(.CNT_W(8), .WIN_W(16), .SYNC_STAGES(2)) u_b (
    .CLK(CLK), .RN(RN), .START(START_b), .WIN_CYCLES(WIN_b),
    .LOGICCPR_1(c_slow), .LOGICCPR_2(c_fast), .LOGICCPR_3(cpr3), .LOGICCPR_4(c_slow),
    .THRESH_1(8'd0), .THRESH_2(8'd255), .THRESH_3(8'd0), .THRESH_4(8'd0),
    .BUSY(BUSY_b), .DONE(DONE_b), .CNT_1(CB1), .CNT_2(CB2), .CNT_3(CB3), .CNT_4(CB4),
    .SAT(SAT_b), .ALARM(ALARM_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs,
                         input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic exp_t mk(input int ec, input int lo, input int hi,
                              input logic [3:0] sat, input logic [3:0] alarm);
    exp_t e;
    e.exp_cyc = ec;
    for (int i = 0; i < 4; i++) begin
      e.lo[i] = 16'(lo);
      e.hi[i] = 16'(hi);
    end
    e.sat   = sat;
    e.alarm = alarm;
    return e;
  endfunction

  task automatic check_result(input string who, input exp_t e, input logic busy,
                              input logic [3:0][15:0] cnt, input logic [3:0] sat,
                              input logic [3:0] alarm);
    chk($sformatf("%s_latency", who), cyc, e.exp_cyc);
    chk($sformatf("%s_busy_in_done", who), busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_rng($sformatf("%s_cnt%0d", who, i + 1), cnt[i], e.lo[i], e.hi[i]);
    end
    chk($sformatf("%s_sat", who), sat, e.sat);
    chk($sformatf("%s_alarm", who), alarm, e.alarm);
  endtask

  always @(negedge CLK) begin
    if (DONE_a) begin
      dn_a++;
      chk("a_done_expected", qa.size() > 0, 1'b1);
      if (qa.size() > 0) begin
        check_result("a", qa.pop_front(), BUSY_a, {CA4, CA3, CA2, CA1}, SAT_a, ALARM_a);
      end
    end else if (qa.size() > 0 && cyc > qa[0].exp_cyc) begin
      chk("a_done_timeout", DONE_a, 1'b1);
      void'(qa.pop_front());
    end
    if (DONE_b) begin
      dn_b++;
      chk("b_done_expected", qb.size() > 0, 1'b1);
      if (qb.size() > 0) begin
        check_result("b", qb.pop_front(), BUSY_b,
                     {8'd0, CB4, 8'd0, CB3, 8'd0, CB2, 8'd0, CB1}, SAT_b, ALARM_b);
      end
    end else if (qb.size() > 0 && cyc > qb[0].exp_cyc) begin
      chk("b_done_timeout", DONE_b, 1'b1);
      void'(qb.pop_front());
    end
  end

  task automatic drain(input int maxc);
    int n = 0;
    while ((qa.size() + qb.size()) > 0 && n < maxc) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_empty", qa.size() + qb.size(), 0);
  endtask

  task automatic start_a_pulse(input exp_t e);
    START_a = 1'b1;
    qa.push_back(e);
    @(negedge CLK);
    START_a = 1'b0;
  endtask

  initial begin
    exp_t e;
    int c0;
    int n;
    int dn0;
    RN = 1'b0; START_a = 1'b0; START_b = 1'b0; WIN_a = '0; WIN_b = '0;
    TH1 = 16'd130; TH2 = 16'd100; TH3 = 16'd100; TH4 = 16'd100; hold3 = 1'b0;
    repeat (3) @(negedge CLK);
    RN = 1'b1;
    @(negedge CLK);
    chk("rst_busy", BUSY_a, 1'b0);
    chk("rst_done", DONE_a, 1'b0);
    chk("rst_cnt", {CA1, CA2, CA3, CA4}, '0);
    chk("rst_cnt_hi", {CA1, CA2}, '0);
    chk("rst_sat", SAT_a, 4'b0);
    chk("rst_alarm", ALARM_a, 4'b0);
    chk("rst_b_cnt2", CB2, 8'd0);

    // Nominal + saturation in parallel; one ignored START mid-window.
    WIN_a = 16'd1000; WIN_b = 16'd1000;
    START_b = 1'b1;
    e = mk(cyc + 1 + 1003, 124, 126, 4'b0010, 4'b0000);
    e.lo[1] = 16'd255; e.hi[1] = 16'd255;
    qb.push_back(e);
    start_a_pulse(mk(cyc + 1 + 1003, 124, 126, 4'b0000, TH ? 4'b0001 : 4'b0000));
    START_b = 1'b0;
    chk("a_busy_after_start", BUSY_a, 1'b1);
    repeat (400) @(negedge CLK);
    START_a = 1'b1;
    @(negedge CLK);
    START_a = 1'b0;
    chk("a_busy_mid", BUSY_a, 1'b1);
    drain(1200);
    repeat (5) @(negedge CLK);
    chk("a_done_count_nominal", dn_a, 1);
    chk("b_done_count_sat", dn_b, 1);

    TH1 = 16'd120;
    start_a_pulse(mk(cyc + 1 + 1003, 124, 126, 4'b0000, 4'b0000));
    drain(1200);

    hold3 = 1'b1;
    repeat (5) @(negedge CLK);
    e = mk(cyc + 1 + 1003, 124, 126, 4'b0000, TH ? 4'b0100 : 4'b0000);
    e.lo[2] = 16'd0; e.hi[2] = 16'd0;
    start_a_pulse(e);
    drain(1200);
    hold3 = 1'b0;

    WIN_a = 16'd0;
    start_a_pulse(mk(cyc + 1 + 3, 0, 0, 4'b0000, TH ? 4'b1111 : 4'b0000));
    drain(20);

    // START held high: DONE every 1004 cycles until released.
    WIN_a = 16'd1000;
    c0 = cyc;
    START_a = 1'b1;
    qa.push_back(mk(c0 + 1 + 1003, 124, 126, 4'b0000, 4'b0000));
    qa.push_back(mk(c0 + 1 + 1003 + 1004, 124, 126, 4'b0000, 4'b0000));
    qa.push_back(mk(c0 + 1 + 1003 + 2008, 124, 126, 4'b0000, 4'b0000));
    n = 0;
    while (qa.size() > 1 && n < 2500) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    chk("a_b2b_busy_rearm", BUSY_a, 1'b1);
    START_a = 1'b0;
    drain(1200);

    // Reset partway through the window.
    dn0 = dn_a;
    START_a = 1'b1;
    @(negedge CLK);
    START_a = 1'b0;
    repeat (502) @(negedge CLK);
    chk("a_busy_before_rst", BUSY_a, 1'b1);
    RN = 1'b0;
    @(negedge CLK);
    RN = 1'b1;
    chk("midrst_busy", BUSY_a, 1'b0);
    chk("midrst_done", DONE_a, 1'b0);
    chk("midrst_cnt1", CA1, 16'd0);
    chk("midrst_cnt2", CA2, 16'd0);
    chk("midrst_cnt3", CA3, 16'd0);
    chk("midrst_cnt4", CA4, 16'd0);
    chk("midrst_sat", SAT_a, 4'b0);
    repeat (1100) @(negedge CLK);
    chk("midrst_no_done", dn_a, dn0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
